// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: op encodings, FSM state
// type and the most-negative operand value for the default width.
package div_pkg;

  localparam int DIV_WIDTH = 64;

  typedef logic [1:0] div_op_t;

  // Matches funct3[1:0] of the RISC-V M-extension divide group
  localparam div_op_t OP_DIV  = 2'b00;
  localparam div_op_t OP_DIVU = 2'b01;
  localparam div_op_t OP_REM  = 2'b10;
  localparam div_op_t OP_REMU = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_ITER,
    ST_FIX,
    ST_DONE
  } div_state_t;

  localparam logic [DIV_WIDTH-1:0] INT_MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};

  // op[0] clear selects the signed variants
  function automatic logic is_signed_op(input div_op_t op);
    return ~op[0];
  endfunction

  // op[1] set selects the remainder as the result
  function automatic logic is_rem_op(input div_op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/seq_div_unit_if.sv
// Request/response bundle between the EX stage and the divider.
interface seq_div_unit_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  div_op_t          op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             div_by_zero;

  modport master (
    output start, a, b, op,
    input  busy, done, result, div_by_zero
  );

  modport slave (
    input  start, a, b, op,
    output busy, done, result, div_by_zero
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract the
// divisor from the widened remainder and keep the difference if it did
// not go negative.
module div_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic        [WIDTH:0] rem_sh;
  logic signed [WIDTH:0] trial;

  // rem < divisor on entry, so the shifted value needs one extra bit and
  // the trial difference always fits in WIDTH+1 signed bits
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    trial  = rem_sh - {1'b0, divisor};
    if (trial >= 0) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = rem_sh[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_div_unit.sv
// Iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
// One quotient bit per cycle; sign handling and the architectural special
// cases (divide by zero, signed overflow) are resolved in the FIX state.
// Build option DIV_FAST_SPECIAL_EN: special cases skip the iterations and
// go straight from PREP to FIX. Results are identical either way.
module seq_div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_div_unit_if.slave bus
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic             signed_op);
    return (signed_op && x[WIDTH-1]) ? negate(x) : x;
  endfunction

  div_state_t       state;
  div_state_t       state_next;

  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  div_op_t          op_p0;

  logic [WIDTH-1:0] rem_p1;
  logic [WIDTH-1:0] quo_p1;
  logic [WIDTH-1:0] dvs_p1;
  logic             sign_q_p1;
  logic             sign_r_p1;
  logic [CNT_W-1:0] cnt_p1;

  logic [WIDTH-1:0] result_q;
  logic             dbz_q;

  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic             b_zero;
  logic             overflow;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_p1),
    .quo      (quo_p1),
    .divisor  (dvs_p1),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  // Special-case detection on the latched operands, plus sign fix-up and overrides
  always_comb begin
    b_zero   = (b_p0 == '0);
    overflow = is_signed_op(op_p0) && (a_p0 == MIN_VAL) && (b_p0 == '1);
    q_fix    = sign_q_p1 ? negate(quo_p1) : quo_p1;
    r_fix    = sign_r_p1 ? negate(rem_p1) : rem_p1;
    if (b_zero) begin
      q_fix = '1;
      r_fix = a_p0;
    end else if (overflow) begin
      q_fix = a_p0;
      r_fix = '0;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // FSM next-state logic; start outside IDLE is dropped
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (bus.start) state_next = ST_PREP;
`ifdef DIV_FAST_SPECIAL_EN
      ST_PREP: state_next = (b_zero || overflow) ? ST_FIX : ST_ITER;
`else
      ST_PREP: state_next = ST_ITER;
`endif
      ST_ITER: if (cnt_p1 == '0) state_next = ST_FIX;
      ST_FIX:  state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, magnitude prep, iteration and result commit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_p0      <= '0;
      b_p0      <= '0;
      op_p0     <= OP_DIV;
      rem_p1    <= '0;
      quo_p1    <= '0;
      dvs_p1    <= '0;
      sign_q_p1 <= 1'b0;
      sign_r_p1 <= 1'b0;
      cnt_p1    <= '0;
      result_q  <= '0;
      dbz_q     <= 1'b0;
    end else begin
      case (state)
        // p0: latch request operands
        ST_IDLE: begin
          if (bus.start) begin
            a_p0  <= bus.a;
            b_p0  <= bus.b;
            op_p0 <= bus.op;
          end
        end
        // p1: strip signs, seed the shift register and counter
        ST_PREP: begin
          rem_p1    <= '0;
          quo_p1    <= magnitude(a_p0, is_signed_op(op_p0));
          dvs_p1    <= magnitude(b_p0, is_signed_op(op_p0));
          sign_q_p1 <= is_signed_op(op_p0) & (a_p0[WIDTH-1] ^ b_p0[WIDTH-1]);
          sign_r_p1 <= is_signed_op(op_p0) & a_p0[WIDTH-1];
          cnt_p1    <= CNT_LAST;
        end
        ST_ITER: begin
          rem_p1 <= rem_step;
          quo_p1 <= quo_step;
          cnt_p1 <= cnt_p1 - CNT_W'(1);
        end
        // p2: commit signed/overridden result
        ST_FIX: begin
          result_q <= is_rem_op(op_p0) ? r_fix : q_fix;
          dbz_q    <= b_zero;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state == ST_PREP) || (state == ST_ITER) || (state == ST_FIX);
  assign bus.done        = (state == ST_DONE);
  assign bus.result      = result_q;
  assign bus.div_by_zero = dbz_q;

endmodule
